muldiv_seq: RTL
===============

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; even, >=4.
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port req_valid  in  1  request present.
REQ-005 SHALL have port req_ready  out  1  request accepted when high with req_valid.
REQ-006 SHALL have port req_op  in  3  op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 SHALL have port req_a  in  WIDTH  operand A / dividend.
REQ-008 SHALL have port req_b  in  WIDTH  operand B / divisor.
REQ-009 SHALL have port resp_valid  out  1  result present.
REQ-010 SHALL have port resp_ready  in  1  consumer takes result.
REQ-011 SHALL have port resp_data  out  WIDTH  result.
REQ-012 SHALL have port resp_err  out  1  op unsupported in this build.
REQ-013 SHALL have port busy  out  1  high in any state except IDLE.

Function
REQ-014 SHALL implement FSM IDLE, PREP, CALC, FIX, DONE.
REQ-015 req_ready SHALL be high only in IDLE; handshake SHALL latch op and operands and move to PREP.
REQ-016 PREP (1 cycle) SHALL take magnitudes of signed operands (MULH: A,B; MULHSU: A only; DIV/REM: both) and record result sign.
REQ-017 CALC SHALL last exactly WIDTH cycles, one bit per cycle, using one shared WIDTH+1-bit adder: shift-add for multiply, restoring shift-subtract for divide.
REQ-018 FIX (1 cycle) SHALL conditionally two's-complement-negate the result (product over 2*WIDTH bits; quotient takes dividend^divisor sign, remainder takes dividend sign).
REQ-019 resp_data SHALL be product[WIDTH-1:0] for MUL, product[2*WIDTH-1:WIDTH] for MULH/MULHSU/MULHU, quotient for DIV/DIVU, remainder for REM/REMU.
REQ-020 Normal latency: resp_valid SHALL rise exactly WIDTH+3 rising edges after the accepting edge.
REQ-021 Divide by zero SHALL be resolved in PREP, skip CALC/FIX: quotient all-ones, remainder = dividend; resp_valid 2 edges after accept.
REQ-022 Signed overflow (DIV/REM, A = most-negative, B = -1) SHALL be resolved in PREP: quotient = A, remainder 0; latency 2 edges.
REQ-023 In DONE resp_valid, resp_data, resp_err SHALL stay stable until resp_ready; on handshake go to IDLE next edge (no same-cycle accept).
REQ-024 resp_valid SHALL be low outside DONE; resp_data SHALL be 0 outside DONE.
REQ-025 req_* changes after the accepting edge SHALL not affect the in-flight result.
REQ-026 resp_err SHALL be 0 for every op when division is compiled in.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, clear all data/counter registers; req_ready=1, resp_valid=0, resp_data=0, resp_err=0, busy=0.
REQ-028 Reset mid-operation (any state) SHALL abandon the op with no response produced after release.
REQ-029 First handshake SHALL be possible on the first rising edge with rst_n high.

Configuration
REQ-030 Macro MULDIV_SEQ_DIV_EN defined SHALL compile in division (ops 4-7) per REQ-017..022.
REQ-031 Without MULDIV_SEQ_DIV_EN ops 4-7 SHALL go PREP->DONE with resp_data=0, resp_err=1, latency 2 edges; no divide datapath or remainder logic present; multiply unchanged.

Verification
REQ-032 MUL A=7, B=0xFFFFFFFD -> resp_data 0xFFFFFFEB, resp_valid exactly 35 edges after accept.
REQ-033 MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU A=0xFFFFFFFF, B=2 -> 0xFFFFFFFF.
REQ-034 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM same -> 0, both 2 edges; DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5.
REQ-035 REM A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFF; DIV same -> 0xFFFFFFFD (-3).
REQ-036 Hold resp_ready low 5 cycles in DONE -> resp_valid/resp_data stable, req_ready low; assert -> IDLE next edge.
REQ-037 rst_n low mid-CALC -> busy=0, resp_valid=0 immediately; no response after release; without MULDIV_SEQ_DIV_EN, DIVU 9/3 -> resp_data 0, resp_err 1, 2 edges.

Source files
------------

// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq -- sequential integer multiply / divide unit (RISC-V M semantics)
//
// One operation at a time. A request is accepted in IDLE. PREP turns signed
// operands into magnitudes and records the result sign. CALC runs WIDTH
// iterations on one shared WIDTH+1-bit adder: shift-add for multiply, restoring
// shift-subtract for divide. FIX applies the recorded sign. DONE holds the
// response until the consumer takes it.
//
// The response registers load one edge after DONE is entered. As a result:
//   normal ops          : resp_valid rises WIDTH+3 edges after the accepting edge
//   div-by-zero/overflow: resp_valid rises 2 edges after the accepting edge
//   unsupported op      : resp_valid rises 2 edges after the accepting edge
//
// Build option:
//   MULDIV_SEQ_DIV_EN  defined   -> division ops 4..7 are implemented
//                      undefined -> ops 4..7 answer resp_data=0, resp_err=1,
//                                   and no divide datapath is built
//
// Parameters:
//   WIDTH       operand/result width (even, >= 4)
// Ports:
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   req_valid   request present
//   req_ready   request accepted when high together with req_valid (IDLE only)
//   req_op      0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   req_a       operand A / dividend
//   req_b       operand B / divisor
//   resp_valid  result present (DONE only)
//   resp_ready  consumer takes the result
//   resp_data   result, zero while resp_valid is low
//   resp_err    op unsupported in this build
//   busy        high in every state except IDLE
// -----------------------------------------------------------------------------
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_err,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;
`ifdef MULDIV_SEQ_DIV_EN
    // The divide step needs the adder carry-out to detect "no borrow".
    localparam int SW = WIDTH + 2;
`else
    localparam int SW = WIDTH + 1;
`endif

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Two's-complement negation over WIDTH bits.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    // Two's-complement negation over the full 2*WIDTH-bit product.
    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + (2*WIDTH)'(1);
    endfunction

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] m_q, m_d;     // multiplicand / divisor magnitude
    logic [WIDTH-1:0] hi_q, hi_d;   // product high half / partial remainder
    logic [WIDTH-1:0] lo_q, lo_d;   // multiplier+product low half / dividend+quotient
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d; // negate product, or quotient
    logic             err_q, err_d;
`ifdef MULDIV_SEQ_DIV_EN
    logic             rneg_q, rneg_d; // negate remainder
    logic             ovf_s;
`endif

    logic             req_ready_q, req_ready_d;
    logic             resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic             resp_err_q, resp_err_d;
    logic             busy_q, busy_d;

    logic             a_signed_s, b_signed_s;
    logic             a_neg_s, b_neg_s;
    logic [WIDTH-1:0] mag_a_s, mag_b_s;
    logic [WIDTH:0]   add_x_s, add_y_s;
    logic             add_cin_s;
    logic [SW-1:0]    add_sum_s;
    logic [WIDTH-1:0] result_s;

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign busy       = busy_q;

    // Operand signedness and magnitudes used by PREP
    always_comb begin
        a_signed_s = (op_q == OP_MULH) || (op_q == OP_MULHSU) ||
                     (op_q == OP_DIV)  || (op_q == OP_REM);
        b_signed_s = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
        a_neg_s    = a_signed_s && a_q[WIDTH-1];
        b_neg_s    = b_signed_s && b_q[WIDTH-1];
        mag_a_s    = a_neg_s ? neg_w(a_q) : a_q;
        mag_b_s    = b_neg_s ? neg_w(b_q) : b_q;
`ifdef MULDIV_SEQ_DIV_EN
        ovf_s      = ((op_q == OP_DIV) || (op_q == OP_REM)) &&
                     (a_q == {1'b1, {(WIDTH-1){1'b0}}}) &&
                     (b_q == {WIDTH{1'b1}});
`endif
    end

    // Shared adder: accumulate for multiply, trial subtract for divide
    always_comb begin
        add_x_s   = {1'b0, hi_q};
        add_y_s   = lo_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}};
        add_cin_s = 1'b0;
`ifdef MULDIV_SEQ_DIV_EN
        if (op_q[2]) begin
            // {remainder, next dividend bit} - divisor, via x + ~y + 1
            add_x_s   = {hi_q, lo_q[WIDTH-1]};
            add_y_s   = ~{1'b0, m_q};
            add_cin_s = 1'b1;
        end else begin
            add_cin_s = 1'b0;
        end
`endif
        add_sum_s = SW'(add_x_s) + SW'(add_y_s) + SW'(add_cin_s);
    end

    // Result selection from the hi/lo working registers
    always_comb begin
        result_s = {WIDTH{1'b0}};
        case (op_q)
            OP_MUL:                       result_s = lo_q;
            OP_MULH, OP_MULHSU, OP_MULHU: result_s = hi_q;
`ifdef MULDIV_SEQ_DIV_EN
            OP_DIV, OP_DIVU:              result_s = lo_q;
            OP_REM, OP_REMU:              result_s = hi_q;
`endif
            default:                      result_s = {WIDTH{1'b0}};
        endcase
    end

    // FSM next state, datapath next values and registered outputs
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        err_d   = err_q;
`ifdef MULDIV_SEQ_DIV_EN
        rneg_d  = rneg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_PREP;
                    op_d    = req_op;
                    a_d     = req_a;
                    b_d     = req_b;
                    err_d   = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PREP: begin
                hi_d  = {WIDTH{1'b0}};
                cnt_d = {CW{1'b0}};
                neg_d = a_neg_s ^ b_neg_s;
                if (op_q[2]) begin
`ifdef MULDIV_SEQ_DIV_EN
                    rneg_d = a_neg_s;
                    m_d    = mag_b_s;
                    lo_d   = mag_a_s;
                    if (b_q == {WIDTH{1'b0}}) begin
                        lo_d    = {WIDTH{1'b1}};
                        hi_d    = a_q;
                        state_d = S_DONE;
                    end else if (ovf_s) begin
                        lo_d    = a_q;
                        hi_d    = {WIDTH{1'b0}};
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
`else
                    lo_d    = {WIDTH{1'b0}};
                    err_d   = 1'b1;
                    state_d = S_DONE;
`endif
                end else begin
                    m_d     = mag_a_s;
                    lo_d    = mag_b_s;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + CW'(1);
`ifdef MULDIV_SEQ_DIV_EN
                if (op_q[2]) begin
                    // Carry out set means the trial subtraction did not borrow.
                    if (add_sum_s[WIDTH+1]) begin
                        hi_d = add_sum_s[WIDTH-1:0];
                    end else begin
                        hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
                    end
                    lo_d = {lo_q[WIDTH-2:0], add_sum_s[WIDTH+1]};
                end else begin
                    hi_d = add_sum_s[WIDTH:1];
                    lo_d = {add_sum_s[0], lo_q[WIDTH-1:1]};
                end
`else
                hi_d = add_sum_s[WIDTH:1];
                lo_d = {add_sum_s[0], lo_q[WIDTH-1:1]};
`endif
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_FIX: begin
                state_d = S_DONE;
`ifdef MULDIV_SEQ_DIV_EN
                if (op_q[2]) begin
                    if (neg_q) begin
                        lo_d = neg_w(lo_q);
                    end else begin
                        lo_d = lo_q;
                    end
                    if (rneg_q) begin
                        hi_d = neg_w(hi_q);
                    end else begin
                        hi_d = hi_q;
                    end
                end else if (neg_q) begin
                    {hi_d, lo_d} = neg_2w({hi_q, lo_q});
                end else begin
                    {hi_d, lo_d} = {hi_q, lo_q};
                end
`else
                if (neg_q) begin
                    {hi_d, lo_d} = neg_2w({hi_q, lo_q});
                end else begin
                    {hi_d, lo_d} = {hi_q, lo_q};
                end
`endif
            end
            S_DONE: begin
                if (resp_valid_q && resp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Response is presented from the second DONE cycle until taken.
        resp_valid_d = (state_q == S_DONE) && !(resp_valid_q && resp_ready);
        resp_data_d  = resp_valid_d ? result_s : {WIDTH{1'b0}};
        resp_err_d   = resp_valid_d && err_q;
        req_ready_d  = (state_d == S_IDLE);
        busy_d       = (state_d != S_IDLE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            op_q         <= 3'd0;
            a_q          <= {WIDTH{1'b0}};
            b_q          <= {WIDTH{1'b0}};
            m_q          <= {WIDTH{1'b0}};
            hi_q         <= {WIDTH{1'b0}};
            lo_q         <= {WIDTH{1'b0}};
            cnt_q        <= {CW{1'b0}};
            neg_q        <= 1'b0;
            err_q        <= 1'b0;
`ifdef MULDIV_SEQ_DIV_EN
            rneg_q       <= 1'b0;
`endif
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= {WIDTH{1'b0}};
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            m_q          <= m_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            cnt_q        <= cnt_d;
            neg_q        <= neg_d;
            err_q        <= err_d;
`ifdef MULDIV_SEQ_DIV_EN
            rneg_q       <= rneg_d;
`endif
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            busy_q       <= busy_d;
        end
    end

endmodule
